// File: rtl/axi_bus_initiator.sv
// Register-bus initiator: single-beat commands in, one-cycle strobes out, read data back after a fixed latency.
// Optional activity counters are enabled with `define AXI_BUS_INITIATOR_STATS_EN.
module axi_bus_initiator #(
  parameter int unsigned READ_LATENCY = 1,
  parameter logic [18:0] ADDR_LIMIT   = 19'h7FFFF,
  parameter int unsigned IDLE_GAP     = 0,
  parameter logic [31:0] ERR_DATA     = 32'hDEADBEEF
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        Cmd_Valid,
  output logic        Cmd_Ready,
  input  logic        Cmd_Write,
  input  logic [18:0] Cmd_Address,
  input  logic [31:0] Cmd_WriteData,
  output logic        Rsp_Valid,
  input  logic        Rsp_Ready,
  output logic [31:0] Rsp_ReadData,
  output logic        Rsp_Error,
  output logic [18:0] AXI_Address,
  output logic        AXI_Read,
  output logic        AXI_Write,
  output logic [31:0] AXI_WriteData,
  input  logic [31:0] AXI_ReadData
`ifdef AXI_BUS_INITIATOR_STATS_EN
  ,
  output logic [15:0] Stat_Reads,
  output logic [15:0] Stat_Writes,
  output logic [7:0]  Stat_Errors
`endif
);

  typedef enum logic [2:0] {StIdle, StGap, StStrobe, StWait, StResp} state_e;

  localparam logic [3:0] GapInit  = 4'(IDLE_GAP);
  localparam logic [3:0] WaitInit = 4'(READ_LATENCY - 1);

  state_e      state_q, state_d;
  logic [18:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic [3:0]  wait_q, wait_d;
  logic [3:0]  gap_q, gap_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;
  logic        strobe;
  logic        in_range;

  assign strobe   = (state_q == StStrobe);
  assign in_range = (Cmd_Address <= ADDR_LIMIT);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    write_d    = write_q;
    wait_d     = wait_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    gap_d      = gap_q;
    if (strobe) begin
      gap_d = GapInit;
    end else if (gap_q != 4'd0) begin
      gap_d = gap_q - 4'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (Cmd_Valid) begin
          if (in_range) begin
            addr_d  = Cmd_Address;
            write_d = Cmd_Write;
            if (Cmd_Write) begin
              wdata_d = Cmd_WriteData;
            end
            state_d = StStrobe;
          end else if (!Cmd_Write) begin
            // Rejected read answers immediately without touching the bus.
            rsp_data_d = ERR_DATA;
            rsp_err_d  = 1'b1;
            state_d    = StResp;
          end
        end
      end
      StGap: begin
        if (gap_d == 4'd0) begin
          state_d = StIdle;
        end
      end
      StStrobe: begin
        if (write_q) begin
          state_d = (GapInit != 4'd0) ? StGap : StIdle;
        end else begin
          wait_d  = WaitInit;
          state_d = StWait;
        end
      end
      StWait: begin
        if (wait_q == 4'd0) begin
          rsp_data_d = AXI_ReadData;
          rsp_err_d  = 1'b0;
          state_d    = StResp;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      StResp: begin
        if (Rsp_Ready) begin
          state_d = (gap_d != 4'd0) ? StGap : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      wait_q     <= '0;
      gap_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      write_q    <= write_d;
      wait_q     <= wait_d;
      gap_q      <= gap_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign Cmd_Ready     = (state_q == StIdle) && RST_N;
  assign AXI_Read      = strobe && !write_q;
  assign AXI_Write     = strobe && write_q;
  assign AXI_Address   = addr_q;
  assign AXI_WriteData = wdata_q;
  assign Rsp_Valid     = (state_q == StResp);
  assign Rsp_ReadData  = rsp_data_q;
  assign Rsp_Error     = rsp_err_q;

`ifdef AXI_BUS_INITIATOR_STATS_EN
  logic [15:0] stat_reads_q;
  logic [15:0] stat_writes_q;
  logic [7:0]  stat_errors_q;
  logic        reject;

  assign reject = Cmd_Valid && Cmd_Ready && !in_range;

  // Counters saturate rather than wrap.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      stat_reads_q  <= '0;
      stat_writes_q <= '0;
      stat_errors_q <= '0;
    end else begin
      if (AXI_Read && (stat_reads_q != '1)) begin
        stat_reads_q <= stat_reads_q + 16'd1;
      end
      if (AXI_Write && (stat_writes_q != '1)) begin
        stat_writes_q <= stat_writes_q + 16'd1;
      end
      if (reject && (stat_errors_q != '1)) begin
        stat_errors_q <= stat_errors_q + 8'd1;
      end
    end
  end

  assign Stat_Reads  = stat_reads_q;
  assign Stat_Writes = stat_writes_q;
  assign Stat_Errors = stat_errors_q;
`endif

endmodule
